// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_OUT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [1:0] dest_t;

endpackage

// File: rtl/demux_4_stream.sv
// Registered 1-to-4 valid/ready stream demux with per-packet destination lock
// and per-output completed-packet counters.
module demux_4_stream
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    input  logic                in_last,
    input  logic [1:0]          in_sel,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_last,
    output logic [4*CW-1:0]     pkt_cnt
);

    function automatic logic [3:0] onehot(input dest_t d);
        logic [3:0] r;
        r = 4'b0000;
        r[d] = 1'b1;
        return r;
    endfunction

    state_t         state_q, state_d;
    dest_t          dest_lock;
    logic           lock_en;
    dest_t          route;
    logic           ovalid;
    dest_t          odest;
    logic           in_acc;
    logic           out_acc;
    logic [CW-1:0]  cnt [NUM_OUT];

    assign out_acc  = ovalid && out_ready[odest];
    // No head-of-line bypass: a stalled sink blocks the input regardless of the next beat's target.
    assign in_ready = !ovalid || out_ready[odest];
    assign in_acc   = in_valid && in_ready;
    assign route    = (state_q == IDLE) ? in_sel : dest_lock;

    always_comb begin
        state_d = state_q;
        lock_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_acc && !in_last) begin
                    state_d = BUSY;
                    lock_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_acc && in_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dest_lock <= '0;
        end else begin
            state_q <= state_d;
            if (lock_en) dest_lock <= in_sel;
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid   <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            odest    <= '0;
        end else if (in_acc) begin
            ovalid   <= 1'b1;
            out_data <= in_data;
            out_last <= in_last;
            odest    <= route;
        end else if (out_acc) begin
            ovalid   <= 1'b0;
        end
    end

    assign out_valid = ovalid ? onehot(odest) : 4'b0000;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_OUT; k++) begin
            if (rst) begin
                cnt[k] <= '0;
            end else if (out_acc && out_last && (odest == dest_t'(k))) begin
                cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            pkt_cnt[k*CW +: CW] = cnt[k];
        end
    end

endmodule

// File: doc/demux_4_stream.md
# demux_4_stream

Registered 1-to-4 stream demultiplexer: routes packets from one valid/ready input stream to one of four output streams chosen by a 2-bit select. The select is locked per packet, and the demux keeps per-output packet counts. It is the fan-out counterpart of the 4-input mux and sits wherever one source must feed one of four sinks without splitting a packet.

## Interface
- `W`, 8, data width in bits
- `CW`, 8, width of each per-output packet counter
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  input beat valid
- `in_ready`  output  1  input beat accepted when `in_valid && in_ready`
- `in_data`  input  W  input payload
- `in_last`  input  1  final beat of packet
- `in_sel`  input  2  destination output; sampled on first beat of packet only
- `out_valid`  output  4  one-hot valid, bit k = output k
- `out_ready`  input  4  per-output ready, bit k = output k
- `out_data`  output  W  payload, shared by all four outputs
- `out_last`  output  1  final-beat flag, shared
- `pkt_cnt`  output  4*CW  packets completed per output; output k at bits [k*CW +: CW]

## Operation
- Input FSM, two states:
  - `IDLE`: no packet open.
  - `BUSY`: packet open, destination locked.
- In `IDLE`, an accepted beat with `in_last`=0 latches `in_sel` into `dest_lock` and moves to `BUSY`.
- In `IDLE`, an accepted beat with `in_last`=1 is a single-beat packet: route it by `in_sel` and stay in `IDLE`.
- In `BUSY`, beats route to `dest_lock`. `in_sel` is ignored. An accepted beat with `in_last`=1 returns to `IDLE`.
- Routing destination for a beat is `in_sel` in `IDLE`, `dest_lock` in `BUSY`.
- Output stage is a one-entry register holding `ovalid`, `out_data`, `out_last` and `odest`.
- `out_valid` = one-hot(`odest`) when `ovalid`=1, else 4'b0000. Only one bit is ever set.
- Output handshake: beat leaves when `ovalid && out_ready[odest]`. `out_ready` bits of other outputs are ignored.
- `in_ready` = `!ovalid || out_ready[odest]`, combinational from `out_ready`. This gives full throughput: one beat per cycle when the sink is ready.
- On input accept, the output register loads the beat. On output accept with no input accept, `ovalid` clears.
- Counters: `pkt_cnt[k]` increments when a beat with `out_last`=1 leaves on output k. It wraps from 2^CW-1 to 0. Counts are per output and independent.
- Sink stall: while `out_ready[odest]`=0, the output register holds `out_data`, `out_last`, `odest` and `ovalid` stable, and `in_ready`=0.
- A blocked output stalls the input even if other outputs are ready. There is no head-of-line bypass.

## Timing
- Reset values:
  - state `IDLE`, `dest_lock` 0
  - `ovalid` 0, so `out_valid` 4'b0000
  - `out_data` 0, `out_last` 0, `odest` 0
  - all `pkt_cnt` 0
  - `in_ready` 1 after reset, since `ovalid`=0
- Latency: a beat accepted at edge N is presented on its output from cycle N+1.
- The counter update is visible the cycle after the last beat leaves.
- Simultaneous output accept and input accept in the same cycle: the register reloads, `ovalid` stays 1, and there is no bubble.
- Reset asserted mid-packet: the FSM returns to `IDLE` and any held beat is dropped.
  - The next accepted beat is treated as a packet start, and its `in_sel` is sampled.
- `in_valid` low mid-packet: the FSM stays in `BUSY` indefinitely and the lock is kept.

## Structure
- Shared package `demux_pkg`:
  - state typedef (`IDLE`, `BUSY`)
  - 2-bit destination typedef
  - constant `NUM_OUT` = 4
- Single module. No sub-module: a one-hot decoder and the counters are inline logic.
- Counters are built as a `NUM_OUT`-entry array packed onto `pkt_cnt`.

## Test plan
- Single-beat packets with `in_sel`=0,1,2,3 and all `out_ready`=1:
  - each data value 0x11..0x44 appears on `out_valid` 0001, 0010, 0100, 1000 one cycle later.
  - `pkt_cnt` = {1,1,1,1}.
- 4-beat packet, `in_sel`=2 on the first beat, then `in_sel` toggled each beat:
  - all 4 beats exit on output 2 only.
  - `pkt_cnt[2]` increments once, on the last beat.
- Output 1 busy: `out_ready`=4'b1101 during a packet to output 1.
  - `in_ready`=0 and the output register is held stable.
  - After `out_ready[1]`=1, the stream resumes with no beat lost or duplicated.
- Back-to-back streaming, 16 beats to output 3 with `out_ready[3]`=1 every cycle:
  - `in_ready` stays 1 throughout, giving 16 beats in 16 cycles.
- Counter wrap with `CW`=8: send 256 single-beat packets to output 0.
  - `pkt_cnt[0]` goes 255 then 0.
  - The other counters stay 0.
- Reset after 2 beats of a packet to output 1:
  - `out_valid`=0 and `pkt_cnt`=0.
  - A following beat with `in_sel`=3 routes to output 3.
